// File: rtl/paddle_ctl_multi_pkg.sv
// Shared types and helpers for the multi-channel paddle controller.
// Source encoding, offset-binary conversion and 9-bit saturating mouse arithmetic.
package paddle_ctl_multi_pkg;

    typedef enum logic [1:0] {
        SRC_PADDLE = 2'd0,
        SRC_STICK  = 2'd1,
        SRC_MOUSE  = 2'd2
    } src_t;

    localparam logic [7:0]        POT_CENTRE = 8'h80;
    localparam logic signed [8:0] ACC_MAX    = 9'sd127;
    localparam logic signed [8:0] ACC_MIN    = -9'sd128;

    // Two's complement to offset binary: centre (0) maps to 0x80.
    function automatic logic [7:0] to_offset(input logic [7:0] v);
        return {~v[7], v[6:0]};
    endfunction

    // Accumulator add that pins at the 8-bit signed range instead of wrapping.
    function automatic logic signed [8:0] sat_add9(input logic signed [8:0] a,
                                                   input logic signed [8:0] b);
        logic signed [9:0] sum;
        sum = {a[8], a} + {b[8], b};
        if (sum > 10'sd127) begin
            return ACC_MAX;
        end
        if (sum < -10'sd128) begin
            return ACC_MIN;
        end
        return sum[8:0];
    endfunction

    function automatic logic signed [8:0] clamp9(input logic signed [8:0] v,
                                                 input logic signed [8:0] lim);
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/paddle_ctl_multi_ch.sv
// One controller channel: source arbitration, axis select, mouse accumulators,
// registered target, optional slew limiter and registered pot/fire outputs.
module paddle_ch
    import paddle_ctl_multi_pkg::*;
#(
    parameter int AXIS_THRESH = 100,
    parameter int SLEW_STEP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_slew,
    input  logic              inv,
    input  logic              stick_btn,
    input  logic              paddle_btn,
    input  logic [15:0]       joy,
    input  logic [7:0]        paddle,
    input  logic              mouse_hit,
    input  logic              mouse_evt,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    input  logic [1:0]        mouse_btn,
    output logic [7:0]        a_out,
    output logic              b_out,
    output logic [1:0]        src
);

    localparam logic signed [7:0] THRESH = 8'(AXIS_THRESH);
    localparam logic [7:0]        STEP   = 8'(SLEW_STEP);

    src_t              src_reg, src_next;
    logic              xy_reg, xy_next;
    logic signed [8:0] mx_reg, mx_next;
    logic signed [8:0] my_reg, my_next;
    logic [7:0]        target_reg, target_next;
    logic [7:0]        cur_reg, cur_next;
    logic [7:0]        a_out_reg;
    logic              b_out_reg, b_out_next;
    logic signed [7:0] joy_x, joy_y;
    logic [7:0]        value;

    assign joy_x = joy[7:0];
    assign joy_y = joy[15:8];

    always_comb begin
        src_next = src_reg;
        if (paddle_btn) begin
            src_next = SRC_PADDLE;
        end else if (stick_btn) begin
            src_next = SRC_STICK;
        end else if (mouse_evt) begin
            src_next = SRC_MOUSE;
        end
    end

    // Entering mouse mode re-centres, so the first delta accumulates from zero.
    always_comb begin
        mx_next = mx_reg;
        my_next = my_reg;
        if (src_next == SRC_MOUSE && mouse_evt) begin
            if (src_reg == SRC_MOUSE) begin
                mx_next = sat_add9(mx_reg, mouse_dx);
                my_next = sat_add9(my_reg, mouse_dy);
            end else begin
                mx_next = sat_add9(9'sd0, mouse_dx);
                my_next = sat_add9(9'sd0, mouse_dy);
            end
        end
    end

    always_comb begin
        xy_next = xy_reg;
        case (src_next)
            SRC_STICK: begin
                if (joy_x > THRESH) begin
                    xy_next = 1'b0;
                end else if (joy_y > THRESH) begin
                    xy_next = 1'b1;
                end
            end
            SRC_MOUSE: begin
                if (mouse_hit) begin
                    if (mouse_btn[0]) begin
                        xy_next = 1'b0;
                    end else if (mouse_btn[1]) begin
                        xy_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        value      = paddle;
        b_out_next = paddle_btn;
        case (src_next)
            SRC_STICK: begin
                value      = xy_next ? joy_y : joy_x;
                b_out_next = stick_btn;
            end
            SRC_MOUSE: begin
                value      = xy_next ? my_next[7:0] : mx_next[7:0];
                b_out_next = mouse_hit & (|mouse_btn);
            end
            default: ;
        endcase
        target_next = to_offset(value);
    end

    // Unsigned approach toward the target, never stepping past it.
    always_comb begin
        cur_next = cur_reg;
        if (SLEW_STEP == 0) begin
            cur_next = target_reg;
        end else if (ce_slew) begin
            if (target_reg > cur_reg) begin
                cur_next = (target_reg - cur_reg > STEP) ? cur_reg + STEP : target_reg;
            end else if (cur_reg > target_reg) begin
                cur_next = (cur_reg - target_reg > STEP) ? cur_reg - STEP : target_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_reg    <= SRC_PADDLE;
            xy_reg     <= 1'b0;
            mx_reg     <= '0;
            my_reg     <= '0;
            target_reg <= POT_CENTRE;
            cur_reg    <= POT_CENTRE;
            a_out_reg  <= POT_CENTRE;
            b_out_reg  <= 1'b0;
        end else begin
            src_reg    <= src_next;
            xy_reg     <= xy_next;
            mx_reg     <= mx_next;
            my_reg     <= my_next;
            target_reg <= target_next;
            cur_reg    <= cur_next;
            a_out_reg  <= cur_next ^ {8{inv}};
            b_out_reg  <= b_out_next;
        end
    end

    assign a_out = a_out_reg;
    assign b_out = b_out_reg;
    assign src   = src_reg;

endmodule

// File: rtl/paddle_ctl_multi.sv
// N-channel paddle/stick/mouse front end: decodes the PS/2 mouse report once
// (strobe, shift, clamp) and fans it out to one paddle_ch per channel.
module paddle_ctl_multi
    import paddle_ctl_multi_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int AXIS_THRESH = 100,
    parameter int MOUSE_SHIFT = 1,
    parameter int MOUSE_CLAMP = 10,
    parameter int SLEW_STEP   = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          ce_slew,
    input  logic [NUM_CH-1:0]                             inv,
    input  logic [NUM_CH-1:0]                             stick_btn,
    input  logic [NUM_CH-1:0]                             paddle_btn,
    input  logic [16*NUM_CH-1:0]                          joy_a,
    input  logic [8*NUM_CH-1:0]                           paddle,
    input  logic [24:0]                                   ps2_mouse,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] mouse_sel,
    output logic [NUM_CH-1:0]                             b_out,
    output logic [8*NUM_CH-1:0]                           a_out,
    output logic [2*NUM_CH-1:0]                           src
);

    localparam int                SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic signed [8:0] CLAMP = 9'(MOUSE_CLAMP);

    logic              strobe_reg;
    logic              mouse_evt;
    logic signed [8:0] dx_raw, dy_raw;
    logic signed [8:0] dx_shift, dy_shift;
    logic signed [8:0] dx_clamp, dy_clamp;
    logic              unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= ps2_mouse[24];
        end
    end

    assign mouse_evt = ps2_mouse[24] ^ strobe_reg;

    assign dx_raw   = $signed({ps2_mouse[4], ps2_mouse[15:8]});
    assign dy_raw   = $signed({ps2_mouse[5], ps2_mouse[23:16]});
    assign dx_shift = dx_raw >>> MOUSE_SHIFT;
    assign dy_shift = dy_raw >>> MOUSE_SHIFT;
    assign dx_clamp = clamp9(dx_shift, CLAMP);
    assign dy_clamp = clamp9(dy_shift, CLAMP);

    assign unused_bits = ^ps2_mouse[3:2];

    // A mouse_sel value beyond the last channel simply matches nobody.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [SEL_W-1:0] CH_ID = SEL_W'(gi);
            logic hit;
            assign hit = (mouse_sel == CH_ID);

            paddle_ch #(
                .AXIS_THRESH (AXIS_THRESH),
                .SLEW_STEP   (SLEW_STEP)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .ce_slew    (ce_slew),
                .inv        (inv[gi]),
                .stick_btn  (stick_btn[gi]),
                .paddle_btn (paddle_btn[gi]),
                .joy        (joy_a[16*gi +: 16]),
                .paddle     (paddle[8*gi +: 8]),
                .mouse_hit  (hit),
                .mouse_evt  (mouse_evt & hit),
                .mouse_dx   (dx_clamp),
                .mouse_dy   (dy_clamp),
                .mouse_btn  (ps2_mouse[1:0]),
                .a_out      (a_out[8*gi +: 8]),
                .b_out      (b_out[gi]),
                .src        (src[2*gi +: 2])
            );
        end
    endgenerate

endmodule

// File: tb/tb_paddle_ctl_multi.sv
// Randomised + directed bench for paddle_ctl_multi: one unslewed and one slewed
// instance share stimulus and are compared every cycle with a behavioural model.
module tb_paddle_ctl_multi;

    localparam int NUM_CH = 4;
    localparam int THR    = 100;
    localparam int SH     = 1;
    localparam int CL     = 10;
    localparam int SLEW_B = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce_slew;
    logic [NUM_CH-1:0]    inv, stick_btn, paddle_btn;
    logic [16*NUM_CH-1:0] joy_a;
    logic [8*NUM_CH-1:0]  paddle;
    logic [24:0]          ps2_mouse;
    logic [1:0]           mouse_sel;
    logic [NUM_CH-1:0]    b_a, b_b;
    logic [8*NUM_CH-1:0]  a_a, a_b;
    logic [2*NUM_CH-1:0]  src_a, src_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    paddle_ctl_multi #(.NUM_CH(NUM_CH), .AXIS_THRESH(THR), .MOUSE_SHIFT(SH),
                       .MOUSE_CLAMP(CL), .SLEW_STEP(0)) dut_a (
        .clk(clk), .reset(reset), .ce_slew(ce_slew), .inv(inv),
        .stick_btn(stick_btn), .paddle_btn(paddle_btn), .joy_a(joy_a),
        .paddle(paddle), .ps2_mouse(ps2_mouse), .mouse_sel(mouse_sel),
        .b_out(b_a), .a_out(a_a), .src(src_a)
    );

    paddle_ctl_multi #(.NUM_CH(NUM_CH), .AXIS_THRESH(THR), .MOUSE_SHIFT(SH),
                       .MOUSE_CLAMP(CL), .SLEW_STEP(SLEW_B)) dut_b (
        .clk(clk), .reset(reset), .ce_slew(ce_slew), .inv(inv),
        .stick_btn(stick_btn), .paddle_btn(paddle_btn), .joy_a(joy_a),
        .paddle(paddle), .ps2_mouse(ps2_mouse), .mouse_sel(mouse_sel),
        .b_out(b_b), .a_out(a_b), .src(src_b)
    );

    // ---------------- behavioural model ----------------
    int m_src [2][NUM_CH];
    int m_xy  [2][NUM_CH];
    int m_mx  [2][NUM_CH];
    int m_my  [2][NUM_CH];
    int m_tgt [2][NUM_CH];
    int m_cur [2][NUM_CH];
    int m_aout[2][NUM_CH];
    int m_bout[2][NUM_CH];
    int m_prev;
    bit m_valid = 1'b0;

    function automatic int sx8(input logic [7:0] b);
        return b[7] ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int mouse_delta(input logic sign, input logic [7:0] mag);
        int d;
        int div;
        div = 1 << SH;
        d = sign ? int'(mag) - 256 : int'(mag);
        d = (d >= 0) ? d / div : -((-d + div - 1) / div);
        if (d > CL) d = CL;
        if (d < -CL) d = -CL;
        return d;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_step();
        int evt, dx, dy, hit, ev, old, ns, jx, jy, v, step, diff;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_src[i][c] = 0; m_xy[i][c] = 0; m_mx[i][c] = 0; m_my[i][c] = 0;
                    m_tgt[i][c] = 128; m_cur[i][c] = 128; m_aout[i][c] = 128; m_bout[i][c] = 0;
                end
            end
            m_prev  = 0;
            m_valid = 1'b1;
            return;
        end
        evt    = (int'(ps2_mouse[24]) != m_prev) ? 1 : 0;
        m_prev = int'(ps2_mouse[24]);
        dx = mouse_delta(ps2_mouse[4], ps2_mouse[15:8]);
        dy = mouse_delta(ps2_mouse[5], ps2_mouse[23:16]);
        for (int i = 0; i < 2; i++) begin
            step = (i == 0) ? 0 : SLEW_B;
            for (int c = 0; c < NUM_CH; c++) begin
                hit = (int'(mouse_sel) == c) ? 1 : 0;
                ev  = evt & hit;
                old = m_src[i][c];
                ns  = old;
                if (paddle_btn[c]) ns = 0;
                else if (stick_btn[c]) ns = 1;
                else if (ev != 0) ns = 2;
                if (ns == 2 && ev != 0) begin
                    if (old != 2) begin
                        m_mx[i][c] = 0;
                        m_my[i][c] = 0;
                    end
                    m_mx[i][c] = sat8(m_mx[i][c] + dx);
                    m_my[i][c] = sat8(m_my[i][c] + dy);
                end
                jx = sx8(joy_a[16*c +: 8]);
                jy = sx8(joy_a[16*c+8 +: 8]);
                if (ns == 1) begin
                    if (jx > THR) m_xy[i][c] = 0;
                    else if (jy > THR) m_xy[i][c] = 1;
                end else if (ns == 2 && hit != 0) begin
                    if (ps2_mouse[0]) m_xy[i][c] = 0;
                    else if (ps2_mouse[1]) m_xy[i][c] = 1;
                end
                case (ns)
                    1: begin
                        v = (m_xy[i][c] != 0) ? jy : jx;
                        m_bout[i][c] = int'(stick_btn[c]);
                    end
                    2: begin
                        v = (m_xy[i][c] != 0) ? m_my[i][c] : m_mx[i][c];
                        m_bout[i][c] = (hit != 0 && ps2_mouse[1:0] != 2'b00) ? 1 : 0;
                    end
                    default: begin
                        v = sx8(paddle[8*c +: 8]);
                        m_bout[i][c] = int'(paddle_btn[c]);
                    end
                endcase
                if (step == 0) begin
                    m_cur[i][c] = m_tgt[i][c];
                end else if (ce_slew) begin
                    diff = m_tgt[i][c] - m_cur[i][c];
                    if (diff > step) diff = step;
                    if (diff < -step) diff = -step;
                    m_cur[i][c] = m_cur[i][c] + diff;
                end
                m_aout[i][c] = inv[c] ? 255 - m_cur[i][c] : m_cur[i][c];
                m_tgt[i][c]  = v + 128;
                m_src[i][c]  = ns;
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic cmp(input string name, input int i, input int c,
                       input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s inst%0d ch%0d: got %0h expected %0h at %0t", name, i, c, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cmp("a_out", i, c, (i == 0) ? 32'(a_a[8*c +: 8]) : 32'(a_b[8*c +: 8]), m_aout[i][c]);
                    cmp("b_out", i, c, (i == 0) ? 32'(b_a[c]) : 32'(b_b[c]), m_bout[i][c]);
                    cmp("src",   i, c, (i == 0) ? 32'(src_a[2*c +: 2]) : 32'(src_b[2*c +: 2]), m_src[i][c]);
                end
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_mouse(input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] btn);
        ps2_mouse[24]    = ~ps2_mouse[24];
        ps2_mouse[4]     = dx[8];
        ps2_mouse[15:8]  = dx[7:0];
        ps2_mouse[5]     = dy[8];
        ps2_mouse[23:16] = dy[7:0];
        ps2_mouse[1:0]   = btn;
    endtask

    task automatic randomize_inputs();
        ce_slew    = 1'($urandom);
        inv        = 4'($urandom);
        stick_btn  = 4'($urandom);
        paddle_btn = 4'($urandom);
        joy_a      = {$urandom, $urandom};
        paddle     = $urandom;
        mouse_sel  = 2'($urandom);
        ps2_mouse[23:0] = 24'($urandom);
    endtask

    logic [7:0] keep0, keep1, keep3;

    initial begin
        // Reset with random inputs; a strobe toggle during reset must be dropped.
        reset = 1'b1;
        randomize_inputs();
        ps2_mouse[24] = 1'b1;
        tick();
        randomize_inputs();
        ps2_mouse[24] = 1'b0;
        tick();
        lit("reset_a_out", 32'(a_a), 32'h8080_8080);
        lit("reset_b_out", 32'(b_a), 32'h0);
        lit("reset_src", 32'(src_a), 32'h0);

        reset = 1'b0; ce_slew = 1'b0; inv = '0; stick_btn = '0; paddle_btn = '0;
        joy_a = '0; paddle = '0; ps2_mouse[23:0] = '0; mouse_sel = 2'd2;
        tick(); tick();
        lit("post_reset_no_evt_src2", 32'(src_a[5:4]), 32'd0);
        lit("post_reset_no_evt_a2", 32'(a_a[23:16]), 32'h80);

        // Paddle on channel 0, then inversion.
        paddle[7:0] = 8'h40; paddle_btn[0] = 1'b1;
        tick();
        paddle_btn[0] = 1'b0;
        lit("paddle_fire0", 32'(b_a[0]), 32'd1);
        tick();
        lit("paddle_a0", 32'(a_a[7:0]), 32'hC0);
        lit("paddle_src0", 32'(src_a[1:0]), 32'd0);
        inv[0] = 1'b1;
        tick();
        lit("paddle_inv_a0", 32'(a_a[7:0]), 32'h3F);
        inv[0] = 1'b0;

        // Stick axis selection on channel 1.
        joy_a[31:16] = {8'd101, 8'd50}; stick_btn[1] = 1'b1;
        tick();
        stick_btn[1] = 1'b0;
        tick();
        lit("stick_y_a1", 32'(a_a[15:8]), 32'hE5);
        lit("stick_src1", 32'(src_a[3:2]), 32'd1);
        joy_a[31:16] = {8'd120, 8'd120};
        tick(); tick();
        lit("stick_x_wins_a1", 32'(a_a[15:8]), 32'hF8);
        joy_a[31:16] = {8'd100, 8'd10};
        tick(); tick();
        lit("stick_thresh_a1", 32'(a_a[15:8]), 32'h8A);

        // Mouse routed to channel 2, clamped deltas, saturation.
        mouse_sel = 2'd2;
        keep0 = a_a[7:0]; keep1 = a_a[15:8]; keep3 = a_a[31:24];
        for (int k = 1; k <= 20; k++) begin
            send_mouse(9'd40, 9'd0, 2'b00);
            tick(); tick();
            lit($sformatf("mouse_acc_%0d", k), 32'(a_a[23:16]), 32'(128 + ((10 * k > 127) ? 127 : 10 * k)));
        end
        lit("mouse_src2", 32'(src_a[5:4]), 32'd2);
        lit("mouse_keep0", 32'(a_a[7:0]), 32'(keep0));
        lit("mouse_keep1", 32'(a_a[15:8]), 32'(keep1));
        lit("mouse_keep3", 32'(a_a[31:24]), 32'(keep3));

        // Re-centre on re-entry, then paddle beats a same-cycle mouse event.
        stick_btn[2] = 1'b1;
        tick();
        stick_btn[2] = 1'b0;
        tick();
        send_mouse(9'd8, 9'd0, 2'b00);
        tick(); tick();
        lit("recentre_a2", 32'(a_a[23:16]), 32'h84);
        paddle_btn[2] = 1'b1;
        send_mouse(9'd8, 9'd0, 2'b01);
        tick();
        paddle_btn[2] = 1'b0;
        lit("priority_src2", 32'(src_a[5:4]), 32'd0);
        lit("priority_fire2", 32'(b_a[2]), 32'd1);

        // Slew on the second instance, channel 0.
        lit("slew_start_b0", 32'(a_b[7:0]), 32'h80);
        paddle[7:0] = 8'h70;
        tick(); tick();
        for (int k = 1; k <= 8; k++) begin
            ce_slew = 1'b1;
            tick();
            ce_slew = 1'b0;
            lit($sformatf("slew_step_%0d", k), 32'(a_b[7:0]), 32'((128 + 16 * k > 240) ? 240 : 128 + 16 * k));
            tick();
            lit($sformatf("slew_hold_%0d", k), 32'(a_b[7:0]), 32'((128 + 16 * k > 240) ? 240 : 128 + 16 * k));
        end

        // Randomised phase, checked by the model every cycle.
        for (int n = 0; n < 2500; n++) begin
            tick();
            reset = ($urandom_range(0, 249) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                paddle_btn[c] = ($urandom_range(0, 19) == 0);
                stick_btn[c]  = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 3) == 0) joy_a = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) paddle = $urandom;
            if ($urandom_range(0, 39) == 0) inv = 4'($urandom);
            if ($urandom_range(0, 29) == 0) mouse_sel = 2'($urandom);
            ce_slew = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) begin
                send_mouse(9'($urandom), 9'($urandom), 2'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
                ps2_mouse[1:0] = 2'($urandom);
            end
        end
        reset = 1'b0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
